// File: rtl/frame_fetch.sv
// Framebuffer reader: issues MCB read bursts for one frame and
// streams the returned colour words out as 24-bit pixels.
module frame_fetch #(
  parameter logic [29:0] BASE_ADDR  = 30'd5242880,
  parameter int          BURST_LEN  = 64,
  parameter int          FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic [20:0] total_pixels,
  input  logic        frame_start,
  input  logic        cmd_full,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic [31:0] rd_data,
  input  logic        rd_empty,
  output logic        rd_en,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done,
  output logic        underrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    CAL,
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        cal_meta;
  logic        cal_sync;
  logic [20:0] tot;
  logic [20:0] req_cnt;
  logic [20:0] pop_cnt;
  logic [20:0] rem;
  logic [6:0]  pend;
  logic [6:0]  amount;
  logic [29:0] ptr;
  logic        issue;
  logic        last_pop;
  logic        start;
  logic        unused_hi;

  assign cmd_instr  = 3'b001;
  assign pix_valid  = (state == RUN) & ~rd_empty;
  assign rd_en      = pix_valid & pix_ready;
  assign pix_data   = rd_data[23:0];
  assign unused_hi  = &{1'b0, rd_data[31:24]};
  assign frame_done = (state == DONE);
  assign busy       = (state == RUN);
  assign start      = (state == IDLE) & frame_start;

  assign rem    = tot - req_cnt;
  assign amount = (rem > 21'(BURST_LEN)) ? 7'(BURST_LEN)
                                         : rem[6:0];
  // cmd_en gating spaces consecutive commands by two cycles
  assign issue  = (state == RUN) && (rem != 21'd0) &&
                  !cmd_full && !cmd_en &&
                  ({1'b0, pend} + {1'b0, amount}
                   <= 8'(FIFO_DEPTH));
  assign last_pop = rd_en && (pop_cnt + 21'd1 == tot);

  always_comb begin
    state_nx = state;
    unique case (state)
      CAL:     if (cal_sync) state_nx = IDLE;
      IDLE:    if (frame_start) state_nx = RUN;
      RUN:     if (last_pop || pop_cnt == tot)
                 state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = CAL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cal_meta <= 1'b0;
      cal_sync <= 1'b0;
    end else begin
      cal_meta <= mem_calib_done;
      cal_sync <= cal_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= CAL;
      cmd_en        <= 1'b0;
      cmd_bl        <= 6'd0;
      cmd_byte_addr <= 30'd0;
      underrun      <= 1'b0;
      tot           <= 21'd0;
      req_cnt       <= 21'd0;
      pop_cnt       <= 21'd0;
      pend          <= 7'd0;
      ptr           <= 30'd0;
    end else begin
      state    <= state_nx;
      cmd_en   <= issue;
      underrun <= (state == RUN) & pix_ready &
                  rd_empty & (pop_cnt != tot);
      if (start) begin
        tot     <= total_pixels;
        req_cnt <= 21'd0;
        pop_cnt <= 21'd0;
        pend    <= 7'd0;
        ptr     <= 30'd0;
      end else begin
        pop_cnt <= pop_cnt + {20'd0, rd_en};
        pend    <= pend + (issue ? amount : 7'd0)
                   - {6'd0, rd_en};
        if (issue) begin
          cmd_bl        <= 6'(amount - 7'd1);
          cmd_byte_addr <= BASE_ADDR + ptr;
          ptr           <= ptr + {21'd0, amount, 2'b00};
          req_cnt       <= req_cnt + {14'd0, amount};
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_fetch.sv
// Directed bench for frame_fetch with a small MCB
// read-port model and an in-order pixel checker.
module tb_frame_fetch;

  localparam logic [29:0] BASE = 30'd5242880;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_calib_done;
  logic [20:0] total_pixels;
  logic        frame_start;
  logic        cmd_full;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic        rd_en;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_done;
  logic        underrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_data[$];
  int          q_t[$];
  logic [29:0] log_addr[$];
  logic [5:0]  log_bl[$];
  int cyc = 0;
  bit hold = 0;
  int max_q = 0;
  int pops = 0;
  int pix_err = 0;
  int done_cnt = 0;
  int und_cnt = 0;

  always #5 clk = ~clk;

  frame_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .mem_calib_done (mem_calib_done),
    .total_pixels   (total_pixels),
    .frame_start    (frame_start),
    .cmd_full       (cmd_full),
    .cmd_en         (cmd_en),
    .cmd_instr      (cmd_instr),
    .cmd_bl         (cmd_bl),
    .cmd_byte_addr  (cmd_byte_addr),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .rd_en          (rd_en),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .frame_done     (frame_done),
    .underrun       (underrun),
    .busy           (busy)
  );

  function automatic logic [31:0] word_of(int idx);
    return {8'hEE, 24'(idx * 66051 + 43981)};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // MCB model: sample at the edge, update the FIFO just after it
  always @(posedge clk) begin
    logic        c_en;
    logic        p;
    logic [5:0]  bl;
    logic [29:0] a;
    logic [23:0] pd;
    logic [31:0] w;
    c_en = cmd_en;
    bl   = cmd_bl;
    a    = cmd_byte_addr;
    p    = rd_en;
    pd   = pix_data;
    cyc++;
    if (frame_done) done_cnt++;
    if (underrun) und_cnt++;
    #1;
    if (p) begin
      w = word_of(pops);
      if (pd !== w[23:0]) pix_err++;
      pops++;
      if (q_data.size() > 0) begin
        void'(q_data.pop_front());
        void'(q_t.pop_front());
      end
    end
    if (c_en) begin
      log_addr.push_back(a);
      log_bl.push_back(bl);
      for (int k = 0; k <= int'(bl); k++) begin
        q_data.push_back(word_of(int'((a - BASE) >> 2) + k));
        q_t.push_back(cyc + LAT);
      end
    end
    if (q_data.size() > max_q) max_q = q_data.size();
    rd_empty = hold || q_data.size() == 0 || q_t[0] > cyc;
    rd_data  = (q_data.size() > 0) ? q_data[0] : 32'd0;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_clear();
    pops = 0;
    pix_err = 0;
    done_cnt = 0;
    und_cnt = 0;
    max_q = 0;
    log_addr.delete();
    log_bl.delete();
  endtask

  task automatic start_frame(input int tot);
    total_pixels = 21'(tot);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!frame_done && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(frame_done), 1);
    tick(2);
  endtask

  task automatic wait_cmd(input int lim);
    int n = 0;
    while (!cmd_en && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_latency", 32'(cmd_en), 1);
  endtask

  task automatic wait_pops(input int cnt);
    int n = 0;
    while (pops < cnt && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("pop_timeout", 32'(pops >= cnt), 1);
  endtask

  task automatic chk_cmds(input int tot);
    int n;
    int bad;
    logic [5:0]  ebl;
    logic [29:0] ea;
    n = (tot + 63) / 64;
    bad = 0;
    chk("cmd_count", log_addr.size(), n);
    for (int i = 0; i < log_addr.size(); i++) begin
      ebl = (i == n - 1) ? 6'((tot - 1) % 64) : 6'd63;
      ea  = BASE + 30'(256 * i);
      if (log_bl[i] !== ebl || log_addr[i] !== ea) bad++;
    end
    chk("cmd_seq", bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int c0;
    int cfail;
    int umiss;
    reset = 1'b1;
    mem_calib_done = 1'b0;
    frame_start = 1'b0;
    cmd_full = 1'b0;
    pix_ready = 1'b1;
    total_pixels = 21'd0;
    rd_empty = 1'b1;
    rd_data = 32'd0;
    tick(2);
    chk("rst_cmd_en", 32'(cmd_en), 0);
    chk("rst_cmd_bl", 32'(cmd_bl), 0);
    chk("rst_addr", 32'(cmd_byte_addr), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("instr", 32'(cmd_instr), 1);
    reset = 1'b0;

    tick(3);
    frame_clear();
    start_frame(100);
    tick(20);
    chk("cal_no_cmd", log_addr.size(), 0);
    chk("cal_busy", 32'(busy), 0);

    mem_calib_done = 1'b1;
    tick(4);
    frame_clear();
    start_frame(100);
    wait_cmd(4);
    chk("first_bl", 32'(cmd_bl), 63);
    chk("first_addr", 32'(cmd_byte_addr), 32'(BASE));
    wait_done(2000);
    chk_cmds(100);
    chk("tail_bl", 32'(log_bl.size() > 1 ? log_bl[1] : 6'd0), 35);
    chk("tail_pops", pops, 100);
    chk("tail_data", pix_err, 0);
    chk("tail_done", done_cnt, 1);

    frame_clear();
    start_frame(1000);
    wait_done(20000);
    chk_cmds(1000);
    chk("med_pops", pops, 1000);
    chk("med_data", pix_err, 0);
    chk("med_done", done_cnt, 1);
    chk("med_depth", 32'(max_q <= 64), 1);

    frame_clear();
    start_frame(300);
    wait_pops(50);
    pix_ready = 1'b0;
    tick(2);
    c0 = log_addr.size();
    tick(498);
    chk("bp_nocmd", log_addr.size(), c0);
    chk("bp_valid", 32'(pix_valid), 1);
    chk("bp_depth", 32'(max_q <= 64), 1);
    pix_ready = 1'b1;
    wait_done(20000);
    chk_cmds(300);
    chk("bp_pops", pops, 300);
    chk("bp_data", pix_err, 0);

    cmd_full = 1'b1;
    hold = 1'b1;
    frame_clear();
    start_frame(200);
    cfail = 0;
    umiss = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) cmd_full = 1'b0;
      @(negedge clk);
      if (i < 20 && cmd_en) cfail++;
      if (!underrun) umiss++;
    end
    chk("full_nocmd", cfail, 0);
    chk("und_gap", umiss, 0);
    chk("full_ncmd", log_addr.size(), 1);
    chk("full_addr", 32'(log_addr.size() > 0 ? log_addr[0] : 30'd0), 32'(BASE));
    chk("full_bl", 32'(log_bl.size() > 0 ? log_bl[0] : 6'd0), 63);
    hold = 1'b0;
    tick(LAT + 3);
    chk("und_clear", 32'(underrun), 0);
    wait_done(20000);
    chk("full_pops", pops, 200);
    chk("full_data", pix_err, 0);

    frame_clear();
    start_frame(0);
    wait_done(5);
    chk("zero_ncmd", log_addr.size(), 0);
    chk("zero_done", done_cnt, 1);

    frame_clear();
    start_frame(1000);
    wait_pops(100);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_cmd_en", 32'(cmd_en), 0);
    chk("mid_bl", 32'(cmd_bl), 0);
    chk("mid_addr", 32'(cmd_byte_addr), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_valid", 32'(pix_valid), 0);
    chk("mid_done", 32'(frame_done), 0);
    q_data.delete();
    q_t.delete();
    @(negedge clk);
    reset = 1'b0;
    frame_clear();
    tick(4);
    start_frame(64);
    wait_cmd(4);
    chk("re_addr", 32'(cmd_byte_addr), 32'(BASE));
    chk("re_bl", 32'(cmd_bl), 63);
    wait_done(2000);
    chk("re_pops", pops, 64);
    chk("re_data", pix_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
